leader_scan_controller: RTL and testbench

Sequencer that drives the 5-bit index input `t` of the combinational `leader_generator` and scans a programmable index range, one index per clock. For each index it samples the generator's 2-bit leader output `l`, compares it with a target leader, counts matches and records the first matching index. It sits between the decoder control path and `leader_generator`, and replaces ad-hoc index stepping with a start/busy/done handshake.

---
 rtl/leader_scan_controller.sv | 123 ++++++++++++
 tb/tb_leader_scan_controller.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/leader_scan_controller.sv
// Scans a programmable, wrapping index range through leader_generator,
// counting matches against a target leader and recording the first hit.
module leader_scan_controller #(
    parameter int T_W = 5,
    parameter int L_W = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [T_W-1:0] t_first,
    input  logic [T_W-1:0] t_last,
    input  logic [L_W-1:0] l_target,
    output logic [T_W-1:0] t,
    input  logic [L_W-1:0] l,
    output logic           busy,
    output logic           done,
    output logic           found,
    output logic [T_W-1:0] found_t,
    output logic [T_W:0]   match_count
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [T_W-1:0] r_t;
    logic [T_W-1:0] r_last;
    logic [L_W-1:0] r_tgt;
    logic           r_end;
    logic           r_pv;
    logic           r_pm;
    logic [T_W-1:0] r_pt;
    logic           r_found;
    logic [T_W-1:0] r_found_t;
    logic [T_W:0]   r_cnt;

    logic w_accept;
    logic w_at_last;
    logic w_hit;

    assign w_accept  = (r_state == IDLE) && start;
    assign w_at_last = (r_t == r_last);
    assign w_hit     = r_pv && r_pm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // The last sample is accumulated one edge after it is taken, so SCAN
    // ends only once the pipelined compare has drained.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = SCAN;
            SCAN:    if (r_pv && r_end) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // The compare of l is registered so the generator path only has to
    // reach a flop, not the accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_t       <= '0;
            r_last    <= '0;
            r_tgt     <= '0;
            r_end     <= 1'b0;
            r_pv      <= 1'b0;
            r_pm      <= 1'b0;
            r_pt      <= '0;
            r_found   <= 1'b0;
            r_found_t <= '0;
            r_cnt     <= '0;
        end else begin
            r_pv <= 1'b0;
            if (w_accept) begin
                r_t       <= t_first;
                r_last    <= t_last;
                r_tgt     <= l_target;
                r_end     <= 1'b0;
                r_found   <= 1'b0;
                r_found_t <= '0;
                r_cnt     <= '0;
            end else if (r_state == SCAN) begin
                if (!r_end) begin
                    r_pv <= 1'b1;
                    r_pm <= (l == r_tgt);
                    r_pt <= r_t;
                    if (w_at_last) begin
                        r_end <= 1'b1;
                    end else begin
                        r_t <= r_t + 1'b1;
                    end
                end
                if (w_hit) begin
                    r_cnt <= r_cnt + 1'b1;
                    if (!r_found) begin
                        r_found   <= 1'b1;
                        r_found_t <= r_pt;
                    end
                end
            end
        end
    end

    assign t           = r_t;
    assign busy        = (r_state == SCAN);
    assign done        = (r_state == DONE);
    assign found       = r_found;
    assign found_t     = r_found_t;
    assign match_count = r_cnt;

endmodule

// File: tb/tb_leader_scan_controller.sv
// Directed bench for leader_scan_controller with a table-driven stand-in
// for leader_generator.
module tb_leader_scan_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [4:0] t_first = '0;
    logic [4:0] t_last = '0;
    logic [1:0] l_target = '0;
    logic [4:0] t;
    logic [1:0] l;
    logic       busy;
    logic       done;
    logic       found;
    logic [4:0] found_t;
    logic [5:0] match_count;

    int n_chk = 0;
    int n_pass = 0;

    logic [1:0] golden [32];

    always #5 clk = ~clk;

    assign l = golden[t];

    leader_scan_controller #(.T_W(5), .L_W(2)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .t_first(t_first),
        .t_last(t_last),
        .l_target(l_target),
        .t(t),
        .l(l),
        .busy(busy),
        .done(done),
        .found(found),
        .found_t(found_t),
        .match_count(match_count)
    );

    typedef struct {
        logic [4:0] first;
        logic [4:0] last;
        logic [1:0] tgt;
        int         cnt;
        int         fnd;
        int         ft;
        int         cyc;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic wait_done(output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag, input bit wrap);
        int cyc;
        bit ok;
        int seq [4];
        @(negedge clk);
        t_first  = v.first;
        t_last   = v.last;
        l_target = v.tgt;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, ".busy0"}, int'(busy), 1);
        chk({tag, ".t0"}, int'(t), int'(v.first));
        seq[0] = int'(t);
        cyc = 0;
        ok  = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc < 4) seq[cyc] = int'(t);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, ".done_seen"}, int'(ok), 1);
        chk({tag, ".latency"}, cyc, v.cyc);
        chk({tag, ".count"}, int'(match_count), v.cnt);
        chk({tag, ".found"}, int'(found), v.fnd);
        chk({tag, ".found_t"}, int'(found_t), v.ft);
        chk({tag, ".t_hold"}, int'(t), int'(v.last));
        if (wrap) begin
            chk({tag, ".seq0"}, seq[0], 30);
            chk({tag, ".seq1"}, seq[1], 31);
            chk({tag, ".seq2"}, seq[2], 0);
            chk({tag, ".seq3"}, seq[3], 1);
        end
        @(posedge clk);
        #1;
        chk({tag, ".done_pulse"}, int'(done), 0);
        chk({tag, ".idle_busy"}, int'(busy), 0);
        chk({tag, ".stable_cnt"}, int'(match_count), v.cnt);
    endtask

    initial begin
        int cyc;
        bit ok;
        int sum;
        golden = '{2'd1, 2'd2, 2'd0, 2'd3, 2'd1, 2'd1, 2'd0, 2'd2,
                   2'd3, 2'd0, 2'd1, 2'd2, 2'd2, 2'd0, 2'd1, 2'd3,
                   2'd0, 2'd2, 2'd1, 2'd1, 2'd3, 2'd0, 2'd2, 2'd1,
                   2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd0, 2'd2, 2'd3};
        vecs[0] = '{5'd0,  5'd31, 2'd0, 8,  1, 2,  33};
        vecs[1] = '{5'd0,  5'd31, 2'd1, 10, 1, 0,  33};
        vecs[2] = '{5'd0,  5'd31, 2'd2, 8,  1, 1,  33};
        vecs[3] = '{5'd0,  5'd31, 2'd3, 6,  1, 3,  33};
        vecs[4] = '{5'd17, 5'd17, 2'd2, 1,  1, 17, 2};
        vecs[5] = '{5'd30, 5'd1,  2'd2, 2,  1, 30, 5};
        vecs[6] = '{5'd30, 5'd1,  2'd3, 1,  1, 31, 5};
        vecs[7] = '{5'd2,  5'd3,  2'd1, 0,  0, 0,  3};
        vecs[8] = '{5'd5,  5'd9,  2'd0, 2,  1, 6,  6};

        #2;
        chk("rst.t", int'(t), 0);
        chk("rst.busy", int'(busy), 0);
        chk("rst.done", int'(done), 0);
        chk("rst.found", int'(found), 0);
        chk("rst.found_t", int'(found_t), 0);
        chk("rst.count", int'(match_count), 0);
        @(negedge clk);
        rst = 1'b0;

        sum = 0;
        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i), i == 5);
            if (i < 4) sum += int'(match_count);
        end
        chk("full.sum", sum, 32);

        // start ignored in SCAN and DONE, range inputs changed mid-scan
        @(negedge clk);
        t_first  = 5'd0;
        t_last   = 5'd31;
        l_target = 2'd1;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        start    = 1'b1;
        t_first  = 5'd17;
        t_last   = 5'd17;
        l_target = 2'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("hs.busy_mid", int'(busy), 1);
        wait_done(cyc, ok);
        chk("hs.done_seen", int'(ok), 1);
        chk("hs.latency", cyc + 6, 33);
        chk("hs.count", int'(match_count), 10);
        chk("hs.found_t", int'(found_t), 0);
        start    = 1'b1;
        l_target = 2'd2;
        @(posedge clk);
        #1;
        chk("hs.done_ign_busy", int'(busy), 0);
        chk("hs.done_ign_t", int'(t), 31);
        chk("hs.hold_cnt", int'(match_count), 10);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("hs.accept_busy", int'(busy), 1);
        chk("hs.accept_t", int'(t), 17);
        chk("hs.accept_clr", int'(match_count), 0);
        wait_done(cyc, ok);
        chk("hs.s_latency", cyc, 2);
        chk("hs.s_count", int'(match_count), 1);
        chk("hs.s_found_t", int'(found_t), 17);
        @(posedge clk);
        #1;

        // reset in the middle of a full scan
        @(negedge clk);
        t_first  = 5'd0;
        t_last   = 5'd31;
        l_target = 2'd0;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (t == 5'd10) break;
            @(posedge clk);
            #1;
        end
        chk("mr.reach10", int'(t), 10);
        chk("mr.partial", int'(match_count > 0), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mr.t", int'(t), 0);
        chk("mr.busy", int'(busy), 0);
        chk("mr.done", int'(done), 0);
        chk("mr.found", int'(found), 0);
        chk("mr.found_t", int'(found_t), 0);
        chk("mr.count", int'(match_count), 0);
        @(posedge clk);
        #1;
        chk("mr.no_done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        run_vec(vecs[0], "mr.rerun", 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
